ecc_err_log: RTL and testbench
==============================

Name: ecc_err_log

Overview: Sequential error-logging stage that sits directly downstream of the ECC read-error address/data capture stage. Each read that the capture stage flags produces one entry holding the error class, the 14-bit read address and the 64-bit data. The block buffers these entries in a small FIFO for firmware or a debug port to drain through a valid/ready interface. It also keeps saturating per-class event counters and a sticky overflow indication.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, minimum 2.
ADDR_W, 14, read-address width.
DATA_W, 64, logged data width.
CNT_W, 16, width of the event counters and the drop counter.

Ports:
CLK  input  1  single clock for all logic.
RST  input  1  synchronous, active-high reset.
R_EN  input  1  read strobe qualifying the flags below.
SB_CORRECT  input  1  ECC correction flag.
DB_DETECT  input  1  ECC detection flag.
R_ADDRr  input  ADDR_W  captured error address from the upstream stage.
error_data  input  DATA_W  captured error data from the upstream stage.
LOG_VALID  output  1  head entry available.
LOG_READY  input  1  consumer accepts the head entry.
LOG_TYPE  output  1  head entry class: 0 = single-bit corrected, 1 = multi-bit uncorrected.
LOG_ADDR  output  ADDR_W  head entry address.
LOG_DATA  output  DATA_W  head entry data.
SB_CNT  output  CNT_W  single-bit event count.
MB_CNT  output  CNT_W  multi-bit event count.
DROP_CNT  output  CNT_W  events lost because the FIFO was full.
OVERFLOW  output  1  sticky flag: at least one event was dropped.
CLR  input  1  synchronous clear of the counters and OVERFLOW; does not clear the FIFO.

Behaviour:
- Event decode (combinational, sampled on the CLK rising edge):
  - sb_evt = R_EN & SB_CORRECT & ~DB_DETECT.
  - mb_evt = R_EN & SB_CORRECT & DB_DETECT.
  - Any other combination is not an event. This includes DB_DETECT=1 with SB_CORRECT=0.
- Push: on an event, {type, R_ADDRr, error_data} is written at the tail in the same cycle. LOG_VALID rises one cycle later (write-to-valid latency 1).
- Pop: the head is consumed on a cycle where LOG_VALID & LOG_READY. LOG_* outputs are registered from FIFO storage and update the cycle after the pop.
- Full: an event that arrives while the FIFO is full and no pop occurs that cycle is dropped.
  - DROP_CNT increments (saturating) and OVERFLOW sets.
  - SB_CNT/MB_CNT still count the event.
- Simultaneous push and pop when full: both are performed; the event is not dropped. Push and pop when empty: the push is performed and the pop is ignored, because LOG_VALID is 0.
- Pointers are log2(DEPTH)+1 bits wide. Wrap-around uses the MSB to distinguish full from empty.
- Counters saturate at all-ones and never wrap.
- CLR: the counters, DROP_CNT and OVERFLOW go to 0 next cycle. If CLR and an event coincide, the clear wins and that event is not counted; it is still pushed if there is space.
- Reset (RST=1 at a CLK edge):
  - Pointers, counters and OVERFLOW go to 0.
  - LOG_VALID goes to 0; LOG_TYPE, LOG_ADDR and LOG_DATA go to 0.
  - Storage contents are don't-care.
  - Reset mid-stream discards all pending entries. Events in the reset cycle are ignored.
- No state machine beyond the FIFO occupancy state (EMPTY / PARTIAL / FULL, derived from the pointers).

Optional Feature:
- Macro: ECC_ERR_LOG_DEDUP_EN.
- Defined:
  - A single-bit event whose R_ADDRr equals the address of the most recently pushed single-bit entry is not pushed; SB_CNT still increments.
  - Last-address tracking is a register plus a valid bit, both cleared by RST and CLR.
  - Multi-bit events are never suppressed and do not update the tracked address.
- Undefined: every event is pushed subject to FIFO space; no tracking register is built.

Decomposition:
- Package ecc_err_log_pkg holds:
  - the entry typedef {type, addr, data};
  - the type constants ERR_SB=1'b0 and ERR_MB=1'b1;
  - the default widths.
- One natural sub-module: ecc_err_fifo, a parameterised synchronous FIFO with full/empty flags and registered read data.
- Event decode, counters and dedup stay in the top level.

Test Plan:
- One SB event (R_EN=1, SB_CORRECT=1, DB_DETECT=0, addr 0x0123, data 0xDEAD_BEEF_0000_0001) -> LOG_VALID=1 next cycle, LOG_TYPE=0, LOG_ADDR=0x0123, SB_CNT=1.
- MB event (SB_CORRECT=1, DB_DETECT=1, addr 0x3FFF) with LOG_READY=0 -> entry held, LOG_TYPE=1, MB_CNT=1. Assert LOG_READY for one cycle -> LOG_VALID=0.
- 10 back-to-back SB events with LOG_READY=0 and DEPTH=8 -> 8 entries held, DROP_CNT=2, OVERFLOW=1, SB_CNT=10. Drain -> entries come out in push order.
- FIFO full with an event and a pop in the same cycle -> DROP_CNT unchanged and occupancy stays 8. DB_DETECT=1 with SB_CORRECT=0 -> no push and no count.
- Preload SB_CNT=0xFFFF -> one more SB event leaves it at 0xFFFF. CLR coincident with an event -> counters 0 and the entry is still pushed.
- With ECC_ERR_LOG_DEDUP_EN, two SB events at addr 0x0040 -> one entry and SB_CNT=2. RST asserted while 3 entries are pending -> LOG_VALID=0 next cycle and all counters 0.

Source files
------------

// File: rtl/ecc_err_log_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecc_err_log_pkg
// Description : Shared types and constants for the ECC error logger.
//               Default widths, error-class encodings, the log entry layout
//               at default widths, and the FIFO occupancy encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ecc_err_log_pkg;

    localparam int c_DEPTH_DEF  = 8;
    localparam int c_ADDR_W_DEF = 14;
    localparam int c_DATA_W_DEF = 64;
    localparam int c_CNT_W_DEF  = 16;

    // Error-class encodings carried in the entry type field
    localparam logic ERR_SB = 1'b0;   // single-bit, corrected
    localparam logic ERR_MB = 1'b1;   // multi-bit, uncorrected

    // Log entry at default widths: {type, addr, data}
    typedef struct packed {
        logic                    err_type;
        logic [c_ADDR_W_DEF-1:0] addr;
        logic [c_DATA_W_DEF-1:0] data;
    } entry_t;

    // FIFO occupancy, derived from the read/write pointers
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

endpackage
`default_nettype wire

// File: rtl/ecc_err_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ecc_err_fifo
// Description : Synchronous FIFO with a registered head-of-queue output.
//               The head register is loaded with the entry that will be at
//               the head after each edge, so a push into an empty FIFO is
//               visible one cycle later and a pop shows the next entry one
//               cycle later.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_push/i_wdata - write request and entry
//               i_pop          - consumer ready (ignored while empty)
//               o_valid/o_rdata- registered head entry
//               o_wr_ok        - write request accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_err_fifo
    import ecc_err_log_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 79
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_wr_ok
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic [c_AW:0]    w_wr_nxt;
    logic [c_AW:0]    w_rd_nxt;
    logic             r_valid;
    logic [WIDTH-1:0] r_rdata;
    occ_t             w_occ;
    logic             w_pop;
    logic             w_push;

    // Pointer MSB differs and index matches -> full
    always_comb begin
        w_occ = OCC_PARTIAL;
        if (r_wr_ptr == r_rd_ptr)
            w_occ = OCC_EMPTY;
        else if (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0])
            w_occ = OCC_FULL;
    end

    // A pop frees a slot in the same cycle, so push-while-full is allowed then
    assign w_pop    = i_pop & (w_occ != OCC_EMPTY);
    assign w_push   = i_push & ((w_occ != OCC_FULL) | w_pop);
    assign w_wr_nxt = r_wr_ptr + (c_AW+1)'(w_push);
    assign w_rd_nxt = r_rd_ptr + (c_AW+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_valid  <= (w_wr_nxt != w_rd_nxt);
            // When the new head is the slot being written right now, storage
            // does not hold it yet: bypass the write data.
            if (w_rd_nxt == r_wr_ptr) begin
                if (w_push)
                    r_rdata <= i_wdata;
            end else begin
                r_rdata <= r_mem[w_rd_nxt[c_AW-1:0]];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_rdata = r_rdata;
    assign o_wr_ok = w_push;

endmodule
`default_nettype wire

// File: rtl/ecc_err_log.sv
`default_nettype none
// ============================================================================
// Module      : ecc_err_log
// Description : ECC error logger. Decodes single-/multi-bit read error
//               events, buffers {type, addr, data} entries in a FIFO drained
//               over LOG_VALID/LOG_READY, and keeps saturating per-class
//               event counters, a drop counter and a sticky OVERFLOW flag.
//               Optional build macro ECC_ERR_LOG_DEDUP_EN: suppress pushing
//               a single-bit event whose address repeats the most recently
//               pushed single-bit entry (the event is still counted).
// Ports       : CLK, RST (sync, active high), CLR (sync counter clear)
//               R_EN, SB_CORRECT, DB_DETECT, R_ADDRr, error_data - capture in
//               LOG_VALID, LOG_READY, LOG_TYPE, LOG_ADDR, LOG_DATA - log out
//               SB_CNT, MB_CNT, DROP_CNT, OVERFLOW - statistics
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_err_log
    import ecc_err_log_pkg::*;
#(
    parameter int DEPTH  = c_DEPTH_DEF,
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int CNT_W  = c_CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              R_EN,
    input  logic              SB_CORRECT,
    input  logic              DB_DETECT,
    input  logic [ADDR_W-1:0] R_ADDRr,
    input  logic [DATA_W-1:0] error_data,
    output logic              LOG_VALID,
    input  logic              LOG_READY,
    output logic              LOG_TYPE,
    output logic [ADDR_W-1:0] LOG_ADDR,
    output logic [DATA_W-1:0] LOG_DATA,
    output logic [CNT_W-1:0]  SB_CNT,
    output logic [CNT_W-1:0]  MB_CNT,
    output logic [CNT_W-1:0]  DROP_CNT,
    output logic              OVERFLOW,
    input  logic              CLR
);

    localparam int              c_ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic                 w_sb_evt;
    logic                 w_mb_evt;
    logic                 w_dup;
    logic                 w_push_req;
    logic                 w_wr_ok;
    logic                 w_drop;
    logic [c_ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]     r_sb_cnt;
    logic [CNT_W-1:0]     r_mb_cnt;
    logic [CNT_W-1:0]     r_drop_cnt;
    logic                 r_overflow;

    // DB_DETECT without SB_CORRECT is deliberately not an event
    assign w_sb_evt = R_EN & SB_CORRECT & ~DB_DETECT;
    assign w_mb_evt = R_EN & SB_CORRECT &  DB_DETECT;

`ifdef ECC_ERR_LOG_DEDUP_EN
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_last_vld;

    assign w_dup = w_sb_evt & r_last_vld & (R_ADDRr == r_last_addr);

    // Track only single-bit entries that actually entered the FIFO
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            r_last_addr <= '0;
            r_last_vld  <= 1'b0;
        end else if (w_sb_evt && w_wr_ok) begin
            r_last_addr <= R_ADDRr;
            r_last_vld  <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    assign w_push_req = (w_sb_evt | w_mb_evt) & ~w_dup;
    // Refused only when full with no pop in the same cycle
    assign w_drop     = w_push_req & ~w_wr_ok;

    ecc_err_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (w_push_req),
        .i_wdata ({(w_mb_evt ? ERR_MB : ERR_SB), R_ADDRr, error_data}),
        .i_pop   (LOG_READY),
        .o_valid (LOG_VALID),
        .o_rdata (w_head),
        .o_wr_ok (w_wr_ok)
    );

    assign {LOG_TYPE, LOG_ADDR, LOG_DATA} = w_head;

    // Clear takes priority over a coincident event
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            r_sb_cnt   <= '0;
            r_mb_cnt   <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_sb_evt && (r_sb_cnt != c_CNT_MAX))
                r_sb_cnt <= r_sb_cnt + CNT_W'(1);
            if (w_mb_evt && (r_mb_cnt != c_CNT_MAX))
                r_mb_cnt <= r_mb_cnt + CNT_W'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != c_CNT_MAX)
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign SB_CNT   = r_sb_cnt;
    assign MB_CNT   = r_mb_cnt;
    assign DROP_CNT = r_drop_cnt;
    assign OVERFLOW = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ecc_err_log.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ecc_err_log
// Description : Self-checking bench for ecc_err_log. Directed scenarios plus
//               a randomized run compared against a queue-based model.
//               Counters are narrowed to 8 bits so saturation is reachable
//               in a few hundred cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_err_log;
    import ecc_err_log_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, r_en, sb_correct, db_detect, log_ready, clr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] err_data;
    logic              log_valid, log_type, overflow;
    logic [ADDR_W-1:0] log_addr;
    logic [DATA_W-1:0] log_data;
    logic [CNT_W-1:0]  sb_cnt, mb_cnt, drop_cnt;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    entry_t            q[$];
    int                m_sb, m_mb, m_drop;
    bit                m_ovf, m_lv;
    logic [ADDR_W-1:0] m_last;

    always #5 clk = ~clk;

    ecc_err_log #(
        .DEPTH (DEPTH), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .CNT_W (CNT_W)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .R_EN       (r_en),
        .SB_CORRECT (sb_correct),
        .DB_DETECT  (db_detect),
        .R_ADDRr    (r_addr),
        .error_data (err_data),
        .LOG_VALID  (log_valid),
        .LOG_READY  (log_ready),
        .LOG_TYPE   (log_type),
        .LOG_ADDR   (log_addr),
        .LOG_DATA   (log_data),
        .SB_CNT     (sb_cnt),
        .MB_CNT     (mb_cnt),
        .DROP_CNT   (drop_cnt),
        .OVERFLOW   (overflow),
        .CLR        (clr)
    );

    // Drive one cycle of inputs, advance the model, and return at edge+1.
    task automatic step(input logic en, input logic sb, input logic db,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic rdy, input logic c, input logic r);
        bit valid, pop, sbe, mbe, dup, req, full, drop, acc;
        entry_t e;
        rst = r; r_en = en; sb_correct = sb; db_detect = db;
        r_addr = a; err_data = d; log_ready = rdy; clr = c;
        if (r) begin
            q.delete();
            m_sb = 0; m_mb = 0; m_drop = 0; m_ovf = 0; m_lv = 0; m_last = '0;
        end else begin
            valid = (q.size() != 0);
            pop   = valid && rdy;
            sbe   = en && sb && !db;
            mbe   = en && sb && db;
            dup   = 0;
`ifdef ECC_ERR_LOG_DEDUP_EN
            dup   = sbe && m_lv && (a == m_last);
`endif
            req   = (sbe || mbe) && !dup;
            full  = (q.size() == DEPTH);
            drop  = req && full && !pop;
            acc   = req && !drop;
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.err_type = mbe; e.addr = a; e.data = d;
                q.push_back(e);
            end
            if (c) begin
                m_sb = 0; m_mb = 0; m_drop = 0; m_ovf = 0; m_lv = 0; m_last = '0;
            end else begin
                if (sbe && m_sb < CMAX) m_sb++;
                if (mbe && m_mb < CMAX) m_mb++;
                if (drop) begin
                    m_ovf = 1;
                    if (m_drop < CMAX) m_drop++;
                end
                if (sbe && acc) begin m_last = a; m_lv = 1; end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic rdy);
        step(0, 0, 0, '0, '0, rdy, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, '0, '0, 0, 0, 1);
        idle(0);
    endtask

    task automatic test_reset();
        step(1, 1, 0, 14'h0055, 64'h1, 0, 0, 0);
        step(1, 1, 1, 14'h0066, 64'h2, 0, 0, 1);
        vectors++;
        if ({log_valid, log_type, log_addr, log_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_log: got v=%b t=%b a=%h d=%h expected all 0",
                     log_valid, log_type, log_addr, log_data);
        end
        vectors++;
        if ({sb_cnt, mb_cnt, drop_cnt, overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_cnt: got sb=%0d mb=%0d drop=%0d ovf=%b expected 0",
                     sb_cnt, mb_cnt, drop_cnt, overflow);
        end
        idle(0);
    endtask

    task automatic test_single_sb();
        do_reset();
        step(1, 1, 0, 14'h0123, 64'hDEAD_BEEF_0000_0001, 0, 0, 0);
        vectors++;
        if ({log_valid, log_type, log_addr, log_data, sb_cnt} !==
            {1'b1, ERR_SB, 14'h0123, 64'hDEAD_BEEF_0000_0001, 8'd1}) begin
            miscompares++;
            $display("FAIL single_sb: got v=%b t=%b a=%h d=%h sb=%0d expected 1 0 0123 deadbeef00000001 1",
                     log_valid, log_type, log_addr, log_data, sb_cnt);
        end
        idle(1);
        vectors++;
        if (log_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_sb_pop: got valid=%b expected 0", log_valid);
        end
    endtask

    task automatic test_mb_hold();
        do_reset();
        step(1, 1, 1, 14'h3FFF, 64'hCAFE_0000_1234_5678, 0, 0, 0);
        idle(0);
        idle(0);
        vectors++;
        if ({log_valid, log_type, log_addr, mb_cnt, sb_cnt} !==
            {1'b1, ERR_MB, 14'h3FFF, 8'd1, 8'd0}) begin
            miscompares++;
            $display("FAIL mb_hold: got v=%b t=%b a=%h mb=%0d sb=%0d expected 1 1 3fff 1 0",
                     log_valid, log_type, log_addr, mb_cnt, sb_cnt);
        end
        idle(1);
        vectors++;
        if (log_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mb_pop: got valid=%b expected 0", log_valid);
        end
    endtask

    task automatic test_fill_drop();
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1, 1, 0, ADDR_W'(i + 16), DATA_W'(i) << 8, 0, 0, 0);
        vectors++;
        if ({drop_cnt, overflow, sb_cnt} !== {8'd2, 1'b1, 8'd10}) begin
            miscompares++;
            $display("FAIL fill_drop: got drop=%0d ovf=%b sb=%0d expected 2 1 10",
                     drop_cnt, overflow, sb_cnt);
        end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (!log_valid || log_addr !== ADDR_W'(i + 16) || log_data !== (DATA_W'(i) << 8)) begin
                miscompares++;
                $display("FAIL drain_order[%0d]: got v=%b a=%h d=%h expected 1 %h %h",
                         i, log_valid, log_addr, log_data, ADDR_W'(i + 16), DATA_W'(i) << 8);
            end
            idle(1);
        end
        vectors++;
        if (log_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty: got valid=%b expected 0", log_valid);
        end
    endtask

    task automatic test_full_push_pop();
        int n;
        logic [ADDR_W-1:0] last;
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            step(1, 1, 0, ADDR_W'(i), '0, 0, 0, 0);
        step(1, 1, 0, 14'h0100, 64'h77, 1, 0, 0);
        vectors++;
        if ({drop_cnt, overflow} !== {8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL full_push_pop: got drop=%0d ovf=%b expected 0 0", drop_cnt, overflow);
        end
        step(1, 0, 1, 14'h0200, 64'h88, 0, 0, 0);
        vectors++;
        if ({sb_cnt, mb_cnt} !== {8'd9, 8'd0}) begin
            miscompares++;
            $display("FAIL db_only: got sb=%0d mb=%0d expected 9 0", sb_cnt, mb_cnt);
        end
        n = 0;
        last = '0;
        for (int k = 0; k < 4 * DEPTH && log_valid; k++) begin
            last = log_addr;
            n++;
            idle(1);
        end
        vectors++;
        if (n != DEPTH || last !== 14'h0100) begin
            miscompares++;
            $display("FAIL full_occupancy: got %0d entries last=%h expected %0d last=0100",
                     n, last, DEPTH);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i <= CMAX; i++)
            step(1, 1, 0, ADDR_W'(i), '0, 1, 0, 0);
        vectors++;
        if (sb_cnt !== 8'hFF) begin
            miscompares++;
            $display("FAIL sb_saturate: got %h expected ff", sb_cnt);
        end
        for (int i = 0; i < CMAX + DEPTH + 4; i++)
            step(1, 1, 1, ADDR_W'(i), '0, 0, 0, 0);
        vectors++;
        if ({mb_cnt, drop_cnt, sb_cnt, overflow} !== {8'hFF, 8'hFF, 8'hFF, 1'b1}) begin
            miscompares++;
            $display("FAIL mb_drop_saturate: got mb=%h drop=%h sb=%h ovf=%b expected ff ff ff 1",
                     mb_cnt, drop_cnt, sb_cnt, overflow);
        end
    endtask

    task automatic test_clr_event();
        int n;
        logic [ADDR_W-1:0] last;
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++)
            step(1, 1, 0, ADDR_W'(i), '0, 0, 0, 0);
        idle(1);
        idle(1);
        step(1, 1, 0, 14'h02AA, 64'h5A5A, 0, 1, 0);
        vectors++;
        if ({sb_cnt, mb_cnt, drop_cnt, overflow} !== '0) begin
            miscompares++;
            $display("FAIL clr_event: got sb=%0d mb=%0d drop=%0d ovf=%b expected 0",
                     sb_cnt, mb_cnt, drop_cnt, overflow);
        end
        n = 0;
        last = '0;
        for (int k = 0; k < 4 * DEPTH && log_valid; k++) begin
            last = log_addr;
            n++;
            idle(1);
        end
        vectors++;
        if (n != DEPTH - 1 || last !== 14'h02AA) begin
            miscompares++;
            $display("FAIL clr_push: got %0d entries last=%h expected %0d last=02aa",
                     n, last, DEPTH - 1);
        end
    endtask

    task automatic test_dedup();
        int n;
        int exp_n;
        do_reset();
        step(1, 1, 0, 14'h0040, 64'h1, 0, 0, 0);
        step(1, 1, 0, 14'h0040, 64'h2, 0, 0, 0);
`ifdef ECC_ERR_LOG_DEDUP_EN
        exp_n = 1;
`else
        exp_n = 2;
`endif
        n = 0;
        for (int k = 0; k < 4 * DEPTH && log_valid; k++) begin
            n++;
            idle(1);
        end
        vectors++;
        if (n != exp_n || sb_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL dedup: got %0d entries sb=%0d expected %0d entries sb=2",
                     n, sb_cnt, exp_n);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1, 1, i[0], ADDR_W'(i + 5), '1, 0, 0, 0);
        step(1, 1, 0, 14'h0999, '1, 0, 0, 1);
        vectors++;
        if ({log_valid, sb_cnt, mb_cnt, drop_cnt, overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_midstream: got v=%b sb=%0d mb=%0d drop=%0d ovf=%b expected 0",
                     log_valid, sb_cnt, mb_cnt, drop_cnt, overflow);
        end
        idle(1);
        vectors++;
        if (log_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_discard: got valid=%b expected 0", log_valid);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            a = ADDR_W'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                 a, {$urandom, $urandom}, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 63) == 0, 0);
            vectors++;
            if (log_valid !== (q.size() != 0)) begin
                miscompares++;
                $display("FAIL rand_valid[%0d]: got %b expected %b", i, log_valid, q.size() != 0);
            end else if (q.size() != 0 &&
                         {log_type, log_addr, log_data} !== {q[0].err_type, q[0].addr, q[0].data}) begin
                miscompares++;
                $display("FAIL rand_head[%0d]: got t=%b a=%h d=%h expected t=%b a=%h d=%h",
                         i, log_type, log_addr, log_data, q[0].err_type, q[0].addr, q[0].data);
            end
            vectors++;
            if ({sb_cnt, mb_cnt, drop_cnt, overflow} !==
                {CNT_W'(m_sb), CNT_W'(m_mb), CNT_W'(m_drop), m_ovf}) begin
                miscompares++;
                $display("FAIL rand_cnt[%0d]: got sb=%0d mb=%0d drop=%0d ovf=%b expected %0d %0d %0d %b",
                         i, sb_cnt, mb_cnt, drop_cnt, overflow, m_sb, m_mb, m_drop, m_ovf);
            end
        end
    endtask

    initial begin
        rst = 1'b1; r_en = 1'b0; sb_correct = 1'b0; db_detect = 1'b0;
        r_addr = '0; err_data = '0; log_ready = 1'b0; clr = 1'b0;
        test_reset();
        test_single_sb();
        test_mb_hold();
        test_fill_drop();
        test_full_push_pop();
        test_saturation();
        test_clr_event();
        test_dedup();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
